mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 255 +++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage between execution and writeback.
//
// Loads and stores go to a request/acknowledge data memory port. A small
// IDLE/BUSY/DONE controller sequences each access. Non-memory
// instructions pass straight to the writeback register.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   clk_en                stage advance enable (IDLE launch and writeback load)
//   i_ex_*                controls, destination, address/result, store data, pc+4
//   o_dmem_req/we/addr/wdata/be, i_dmem_ack/rdata   data memory handshake
//   o_mem_stall           combinational hold request to upstream stages
//   o_mem_fault/_code     one-cycle fault pulse: 01 misaligned, 10 illegal, 11 timeout
//   o_mem_*               writeback register contents
module mem_stage #(
  parameter int ACK_TIMEOUT = 16,
  parameter int REG_ADDR    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                i_ex_mem_to_reg,
  input  logic                i_ex_reg_wr,
  input  logic                i_ex_result_src,
  input  logic                i_ex_mem_rd,
  input  logic                i_ex_mem_wr,
  input  logic [REG_ADDR-1:0] i_ex_reg_destination,
  input  logic [2:0]          i_ex_funct3,
  input  logic [31:0]         i_ex_alu_result,
  input  logic [31:0]         i_ex_data2,
  input  logic [31:0]         i_ex_pc_plus_4,
  output logic                o_dmem_req,
  output logic                o_dmem_we,
  output logic [31:0]         o_dmem_addr,
  output logic [31:0]         o_dmem_wdata,
  output logic [3:0]          o_dmem_be,
  input  logic                i_dmem_ack,
  input  logic [31:0]         i_dmem_rdata,
  output logic                o_mem_stall,
  output logic                o_mem_fault,
  output logic [1:0]          o_mem_fault_code,
  output logic                o_mem_reg_wr,
  output logic                o_mem_mem_to_reg,
  output logic                o_mem_result_src,
  output logic [REG_ADDR-1:0] o_mem_reg_destination,
  output logic [31:0]         o_mem_read_data,
  output logic [31:0]         o_mem_alu_result,
  output logic [31:0]         o_mem_pc_plus_4
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_ILLEGAL  = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [31:0]         hold_r;
  logic                cap_reg_wr_r;
  logic                cap_mem_to_reg_r;
  logic                cap_result_src_r;
  logic [REG_ADDR-1:0] cap_dest_r;
  logic [31:0]         cap_alu_r;
  logic [31:0]         cap_pc_r;
  logic [2:0]          cap_funct3_r;

  logic                access_s;
  logic                illegal_s;
  logic                misaligned_s;
  logic                launch_ok_s;
  logic [3:0]          be_s;
  logic [31:0]         wdata_s;

  // Select the addressed lane of a read word and sign/zero extend it.
  function automatic logic [31:0] load_format(input logic [31:0] rdata,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  assign access_s    = i_ex_mem_rd | i_ex_mem_wr;
  assign launch_ok_s = access_s & ~illegal_s & ~misaligned_s;

  // Legality, alignment and store lane placement of the incoming access.
  always_comb begin
    illegal_s    = 1'b0;
    misaligned_s = 1'b0;
    be_s         = 4'b1111;
    wdata_s      = i_ex_data2;
    if (i_ex_mem_rd && i_ex_mem_wr) begin
      illegal_s = 1'b1;
    end else if (i_ex_mem_rd) begin
      case (i_ex_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_s = 1'b0;
        default:                                illegal_s = 1'b1;
      endcase
    end else if (i_ex_mem_wr) begin
      illegal_s = (i_ex_funct3 > 3'b010);
    end else begin
      illegal_s = 1'b0;
    end
    case (i_ex_funct3[1:0])
      2'b00: begin
        be_s    = 4'b0001 << i_ex_alu_result[1:0];
        wdata_s = {4{i_ex_data2[7:0]}};
      end
      2'b01: begin
        misaligned_s = i_ex_alu_result[0];
        be_s         = i_ex_alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_s      = {2{i_ex_data2[15:0]}};
      end
      2'b10: begin
        misaligned_s = |i_ex_alu_result[1:0];
      end
      default: begin
        misaligned_s = 1'b0;
      end
    endcase
  end

  // Stall covers the launch cycle and every BUSY cycle; forced low in reset.
  assign o_mem_stall = rst_n & (((state_r == IDLE) & launch_ok_s) | (state_r == BUSY));

  // Access controller, memory port registers and writeback register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r               <= IDLE;
      cnt_r                 <= '0;
      hold_r                <= 32'h0000_0000;
      cap_reg_wr_r          <= 1'b0;
      cap_mem_to_reg_r      <= 1'b0;
      cap_result_src_r      <= 1'b0;
      cap_dest_r            <= '0;
      cap_alu_r             <= 32'h0000_0000;
      cap_pc_r              <= 32'h0000_0000;
      cap_funct3_r          <= 3'b000;
      o_dmem_req            <= 1'b0;
      o_dmem_we             <= 1'b0;
      o_dmem_addr           <= 32'h0000_0000;
      o_dmem_wdata          <= 32'h0000_0000;
      o_dmem_be             <= 4'b0000;
      o_mem_fault           <= 1'b0;
      o_mem_fault_code      <= 2'b00;
      o_mem_reg_wr          <= 1'b0;
      o_mem_mem_to_reg      <= 1'b0;
      o_mem_result_src      <= 1'b0;
      o_mem_reg_destination <= '0;
      o_mem_read_data       <= 32'h0000_0000;
      o_mem_alu_result      <= 32'h0000_0000;
      o_mem_pc_plus_4       <= 32'h0000_0000;
    end else begin
      o_mem_fault      <= 1'b0;
      o_mem_fault_code <= 2'b00;
      case (state_r)
        IDLE: begin
          if (clk_en) begin
            if (launch_ok_s) begin
              o_dmem_req       <= 1'b1;
              o_dmem_we        <= i_ex_mem_wr;
              o_dmem_addr      <= i_ex_alu_result;
              o_dmem_wdata     <= wdata_s;
              o_dmem_be        <= be_s;
              cap_reg_wr_r     <= i_ex_reg_wr;
              cap_mem_to_reg_r <= i_ex_mem_to_reg;
              cap_result_src_r <= i_ex_result_src;
              cap_dest_r       <= i_ex_reg_destination;
              cap_alu_r        <= i_ex_alu_result;
              cap_pc_r         <= i_ex_pc_plus_4;
              cap_funct3_r     <= i_ex_funct3;
              cnt_r            <= '0;
              state_r          <= BUSY;
            end else begin
              // Pass-through, or a rejected access retired without a register write.
              o_mem_reg_wr          <= i_ex_reg_wr & ~access_s;
              o_mem_mem_to_reg      <= i_ex_mem_to_reg;
              o_mem_result_src      <= i_ex_result_src;
              o_mem_reg_destination <= i_ex_reg_destination;
              o_mem_alu_result      <= i_ex_alu_result;
              o_mem_pc_plus_4       <= i_ex_pc_plus_4;
              if (access_s) begin
                o_mem_fault      <= 1'b1;
                o_mem_fault_code <= illegal_s ? FC_ILLEGAL : FC_MISALIGN;
              end
            end
          end
        end
        BUSY: begin
          // Ack is checked before the timeout so an ack in the last cycle completes.
          if (i_dmem_ack) begin
            hold_r     <= load_format(i_dmem_rdata, cap_funct3_r, o_dmem_addr[1:0]);
            o_dmem_req <= 1'b0;
            state_r    <= DONE;
          end else if (cnt_r == CNT_LAST) begin
            o_dmem_req            <= 1'b0;
            o_mem_fault           <= 1'b1;
            o_mem_fault_code      <= FC_TIMEOUT;
            o_mem_reg_wr          <= 1'b0;
            o_mem_mem_to_reg      <= cap_mem_to_reg_r;
            o_mem_result_src      <= cap_result_src_r;
            o_mem_reg_destination <= cap_dest_r;
            o_mem_alu_result      <= cap_alu_r;
            o_mem_pc_plus_4       <= cap_pc_r;
            state_r               <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (clk_en) begin
            o_mem_reg_wr          <= cap_reg_wr_r;
            o_mem_mem_to_reg      <= cap_mem_to_reg_r;
            o_mem_result_src      <= cap_result_src_r;
            o_mem_reg_destination <= cap_dest_r;
            o_mem_alu_result      <= cap_alu_r;
            o_mem_pc_plus_4       <= cap_pc_r;
            if (!o_dmem_we) begin
              o_mem_read_data <= hold_r;
            end
            state_r <= IDLE;
          end
        end
        default: begin
          o_dmem_req <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed accesses with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_stage;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n, clk_en;
  logic        ex_m2r, ex_reg_wr, ex_src, ex_rd, ex_wr;
  logic [4:0]  ex_dest;
  logic [2:0]  ex_f3;
  logic [31:0] ex_alu, ex_d2, ex_pc;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  logic        dmem_req, dmem_we, mem_stall, mem_fault, mem_reg_wr, mem_m2r, mem_src;
  logic [31:0] dmem_addr, dmem_wdata, mem_rd, mem_alu, mem_pc;
  logic [3:0]  dmem_be;
  logic [1:0]  fault_code;
  logic [4:0]  mem_dest;

  mem_stage #(.ACK_TIMEOUT(TO), .REG_ADDR(5)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .i_ex_mem_to_reg(ex_m2r), .i_ex_reg_wr(ex_reg_wr), .i_ex_result_src(ex_src),
    .i_ex_mem_rd(ex_rd), .i_ex_mem_wr(ex_wr), .i_ex_reg_destination(ex_dest),
    .i_ex_funct3(ex_f3), .i_ex_alu_result(ex_alu), .i_ex_data2(ex_d2),
    .i_ex_pc_plus_4(ex_pc),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be),
    .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
    .o_mem_stall(mem_stall), .o_mem_fault(mem_fault), .o_mem_fault_code(fault_code),
    .o_mem_reg_wr(mem_reg_wr), .o_mem_mem_to_reg(mem_m2r), .o_mem_result_src(mem_src),
    .o_mem_reg_destination(mem_dest), .o_mem_read_data(mem_rd),
    .o_mem_alu_result(mem_alu), .o_mem_pc_plus_4(mem_pc)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int obs_stall = 0;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  logic        obs_we;

  // Model: one in-flight access, described by what has happened to it.
  bit          pending, ready;
  int          waited;
  logic        c_load, c_reg_wr, c_m2r, c_src;
  logic [2:0]  c_f3;
  logic [4:0]  c_dest;
  logic [31:0] c_addr, c_alu, c_pc, hold;
  logic        e_req, e_we, e_fault, e_reg_wr, e_m2r, e_src;
  logic [31:0] e_addr, e_wdata, e_rdata, e_alu, e_pc;
  logic [3:0]  e_be;
  logic [1:0]  e_code;
  logic [4:0]  e_dest;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << int'(f3[1:0]);
  endfunction

  function automatic bit is_illegal(input logic rd, input logic wr, input logic [2:0] f3);
    if (rd && wr) return 1'b1;
    if (rd) return !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (wr) return f3 > 3'd2;
    return 1'b0;
  endfunction

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] rdata, input logic [2:0] f3,
                                             input logic [31:0] a);
    logic [31:0] v;
    v = rdata >> (8 * int'(a[1:0]));
    case (f3)
      3'd0: begin v = v % 32'd256;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'd1: begin v = v % 32'd65536; if (v >= 32'd32768) v = v - 32'd65536; end
      3'd4: v = v % 32'd256;
      3'd5: v = v % 32'd65536;
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] d, input int sz);
    if (sz == 1) return (d % 32'd256) * 32'h01010101;
    if (sz == 2) return (d % 32'd65536) * 32'h00010001;
    return d;
  endfunction

  task automatic model_reset();
    pending = 0; ready = 0; waited = 0; hold = 32'd0;
    e_req = 0; e_we = 0; e_addr = 32'd0; e_wdata = 32'd0; e_be = 4'd0;
    e_fault = 0; e_code = 2'd0; e_reg_wr = 0; e_m2r = 0; e_src = 0;
    e_dest = 5'd0; e_rdata = 32'd0; e_alu = 32'd0; e_pc = 32'd0;
  endtask

  task automatic wb(input logic rw, input logic m2r, input logic src, input logic [4:0] d,
                    input logic [31:0] alu, input logic [31:0] pc);
    e_reg_wr = rw; e_m2r = m2r; e_src = src; e_dest = d; e_alu = alu; e_pc = pc;
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_step();
    bit acc;
    acc = ex_rd | ex_wr;
    e_fault = 0; e_code = 2'd0;
    if (!rst_n) return;
    if (ready) begin
      if (clk_en) begin
        wb(c_reg_wr, c_m2r, c_src, c_dest, c_alu, c_pc);
        if (c_load) e_rdata = hold;
        ready = 0;
      end
    end else if (pending) begin
      waited++;
      if (dmem_ack) begin
        hold = load_value(dmem_rdata, c_f3, c_addr);
        pending = 0; ready = 1; e_req = 0;
      end else if (waited == TO) begin
        pending = 0; e_req = 0; e_fault = 1; e_code = 2'd3;
        wb(1'b0, c_m2r, c_src, c_dest, c_alu, c_pc);
      end
    end else if (clk_en) begin
      if (!acc) begin
        wb(ex_reg_wr, ex_m2r, ex_src, ex_dest, ex_alu, ex_pc);
      end else if (is_illegal(ex_rd, ex_wr, ex_f3) || is_misaligned(ex_f3, ex_alu)) begin
        e_fault = 1;
        e_code = is_illegal(ex_rd, ex_wr, ex_f3) ? 2'd2 : 2'd1;
        wb(1'b0, ex_m2r, ex_src, ex_dest, ex_alu, ex_pc);
      end else begin
        pending = 1; waited = 0;
        c_load = ex_rd; c_reg_wr = ex_reg_wr; c_m2r = ex_m2r; c_src = ex_src;
        c_f3 = ex_f3; c_dest = ex_dest; c_addr = ex_alu; c_alu = ex_alu; c_pc = ex_pc;
        e_req = 1; e_we = ex_wr; e_addr = ex_alu;
        e_be = 4'(((1 << size_of(ex_f3)) - 1) << int'(ex_alu[1:0]));
        e_wdata = store_data(ex_d2, size_of(ex_f3));
      end
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic check_all();
    bit exp_stall;
    exp_stall = rst_n && (pending || (!ready && (ex_rd | ex_wr) &&
                !is_illegal(ex_rd, ex_wr, ex_f3) && !is_misaligned(ex_f3, ex_alu)));
    chk("stall", 32'(mem_stall), 32'(exp_stall));
    chk("req", 32'(dmem_req), 32'(e_req));
    chk("fault", 32'(mem_fault), 32'(e_fault));
    chk("fault_code", 32'(fault_code), 32'(e_code));
    chk("reg_wr", 32'(mem_reg_wr), 32'(e_reg_wr));
    chk("mem_to_reg", 32'(mem_m2r), 32'(e_m2r));
    chk("result_src", 32'(mem_src), 32'(e_src));
    chk("dest", 32'(mem_dest), 32'(e_dest));
    chk("read_data", mem_rd, e_rdata);
    chk("alu_result", mem_alu, e_alu);
    chk("pc_plus_4", mem_pc, e_pc);
    if (e_req) begin
      chk("dmem_we", 32'(dmem_we), 32'(e_we));
      chk("dmem_addr", dmem_addr, e_addr);
      chk("dmem_wdata", dmem_wdata, e_wdata);
      chk("dmem_be", 32'(dmem_be), 32'(e_be));
    end
    if (mem_stall) obs_stall++;
    if (dmem_req) begin obs_be = dmem_be; obs_wdata = dmem_wdata; obs_we = dmem_we; end
  endtask

  // Inputs are applied just after a rising edge; check, step model, next edge.
  task automatic tick();
    #1;
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
    ex_rd = rd; ex_wr = wr; ex_f3 = f3; ex_alu = a; ex_d2 = d;
    ex_reg_wr = 1'b1; ex_m2r = rd; ex_src = 1'b0; ex_dest = 5'd7; ex_pc = a + 32'd4;
  endtask

  // Launch one access; ack arrives in BUSY cycle ack_at (0 = never).
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           input int ack_at, input logic [31:0] rdata);
    set_ex(rd, wr, f3, a, d);
    clk_en = 1'b1; dmem_ack = 1'b0;
    tick();
    for (int i = 1; i <= TO; i++) begin
      dmem_ack = (i == ack_at);
      dmem_rdata = (i == ack_at) ? rdata : $urandom;
      tick();
      if (i == ack_at) break;
    end
    dmem_ack = 1'b0;
    if (ack_at != 0) tick();
    ex_rd = 1'b0; ex_wr = 1'b0;
  endtask

  task automatic rand_ex();
    int kind;
    int sz;
    kind = $urandom_range(0, 9);
    ex_reg_wr = 1'($urandom); ex_m2r = 1'($urandom); ex_src = 1'($urandom);
    ex_dest = 5'($urandom); ex_pc = $urandom; ex_d2 = $urandom; ex_alu = $urandom;
    ex_f3 = 3'($urandom);
    if (kind <= 3) begin
      ex_rd = 1'b0; ex_wr = 1'b0;
    end else if (kind <= 7) begin
      ex_rd = (kind <= 5); ex_wr = (kind > 5);
      if (ex_rd) ex_f3 = (ex_f3 == 3'd3 || ex_f3 > 3'd5) ? 3'd2 : ex_f3;
      else       ex_f3 = 3'($urandom_range(0, 2));
      sz = size_of(ex_f3);
      if ($urandom_range(0, 3) != 0) ex_alu = ex_alu & ~(32'(sz) - 32'd1);
    end else begin
      ex_rd = 1'($urandom); ex_wr = 1'($urandom);
      if (!ex_rd && !ex_wr) ex_rd = 1'b1;
    end
  endtask

  initial begin
    int ack_pct;
    rst_n = 1'b0; clk_en = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    set_ex(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    ex_reg_wr = 1'b0; ex_m2r = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_fault", 32'(mem_fault), 32'd0);
    chk("rst_reg_wr", 32'(mem_reg_wr), 32'd0);
    chk("rst_read_data", mem_rd, 32'd0);
    rst_n = 1'b1;

    // Non-memory instruction passes through in one cycle.
    set_ex(1'b0, 1'b0, 3'd0, 32'h55, 32'd0);
    clk_en = 1'b1; obs_stall = 0;
    tick();
    chk("pass_reg_wr", 32'(mem_reg_wr), 32'd1);
    chk("pass_alu", mem_alu, 32'h55);
    chk("pass_no_stall", 32'(obs_stall), 32'd0);

    // LW 0x100, ack in third BUSY cycle.
    obs_stall = 0;
    do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 3, 32'hDEADBEEF);
    chk("lw_stall_cycles", 32'(obs_stall), 32'd4);
    chk("lw_be", 32'(obs_be), 32'hF);
    chk("lw_read_data", mem_rd, 32'hDEADBEEF);

    do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 1, 32'h80FFFF00);
    chk("lb_read_data", mem_rd, 32'hFFFFFF80);
    do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 2, 32'h80FFFF00);
    chk("lbu_read_data", mem_rd, 32'h00000080);

    do_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'd0);
    chk("sh_be", 32'(obs_be), 32'hC);
    chk("sh_wdata", obs_wdata, 32'hABCDABCD);
    chk("sh_we", 32'(obs_we), 32'd1);
    chk("sh_read_data_kept", mem_rd, 32'h00000080);

    // Misaligned LW.
    set_ex(1'b1, 1'b0, 3'b010, 32'h101, 32'd0);
    obs_stall = 0;
    tick();
    chk("mis_fault", 32'(mem_fault), 32'd1);
    chk("mis_code", 32'(fault_code), 32'd1);
    chk("mis_reg_wr", 32'(mem_reg_wr), 32'd0);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_no_stall", 32'(obs_stall), 32'd0);
    ex_rd = 1'b0;

    // Timeout.
    obs_stall = 0;
    do_access(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 0, 32'd0);
    chk("to_req", 32'(dmem_req), 32'd0);
    chk("to_fault", 32'(mem_fault), 32'd1);
    chk("to_code", 32'(fault_code), 32'd3);
    chk("to_reg_wr", 32'(mem_reg_wr), 32'd0);
    chk("to_stall_cycles", 32'(obs_stall), 32'(TO + 1));
    tick();
    chk("to_idle_no_stall", 32'(mem_stall), 32'd0);

    // Reset in the middle of BUSY, then a stale ack.
    set_ex(1'b1, 1'b0, 3'b010, 32'h400, 32'd0);
    dmem_ack = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_stall", 32'(mem_stall), 32'd0);
    chk("mid_rst_read_data", mem_rd, 32'd0);
    chk("mid_rst_alu", mem_alu, 32'd0);
    chk("mid_rst_be", 32'(dmem_be), 32'd0);
    model_reset();
    tick();
    ex_rd = 1'b0; rst_n = 1'b1; clk_en = 1'b0; dmem_ack = 1'b1;
    tick();
    chk("stale_ack_req", 32'(dmem_req), 32'd0);
    chk("stale_ack_reg_wr", 32'(mem_reg_wr), 32'd0);
    dmem_ack = 1'b0;

    // Randomized traffic.
    ack_pct = 35;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 300 == 0) begin
        case ($urandom_range(0, 2))
          0: ack_pct = 35;
          1: ack_pct = 0;
          default: ack_pct = 6;
        endcase
      end
      if (!pending) rand_ex();
      clk_en = ($urandom_range(0, 9) < 8);
      dmem_ack = ($urandom_range(0, 99) < ack_pct);
      dmem_rdata = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
